// File: rtl/rob_commit_unit.sv
// Retirement stage at the ROB head: in-order commit of register results,
// store drain through a valid/ready port, and MTC0 simulation status.
package mips_core_pkg;
    parameter int ROB_DEPTH_BITS = 5;

    typedef enum logic [1:0] {
        IT_ALU    = 2'b00,
        IT_LOAD   = 2'b01,
        IT_STORE  = 2'b10,
        IT_BRANCH = 2'b11
    } inst_type_t;

    // 194-bit ROB entry shared with dispatch/writeback
    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [1:0]  inst_type;
        logic [31:0] pc;
        logic [4:0]  logic_reg_dest;
        logic [5:0]  reg_dest;
        logic [5:0]  old_reg_dest;
        logic [31:0] value;
        logic [25:0] mem_dest;
        logic        branch_taken;
        logic [31:0] branch_target;
        logic        mispredict;
        logic        exception;
        logic        is_mtc0;
        logic        mtc0_pass;
        logic        mtc0_fail;
        logic        mtc0_done;
        logic [31:0] inst;
        logic [5:0]  src_preg_a;
        logic [5:0]  src_preg_b;
    } rob_entry;
endpackage

module rob_commit_unit
    import mips_core_pkg::*;
#(
    parameter int ROB_DEPTH_BITS = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 26
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rob_empty,
    input  rob_entry                  head_entry,
    input  logic [ROB_DEPTH_BITS-1:0] head_tag,
    input  logic                      flush,
    output logic                      commit_pop,
    output logic                      arf_we,
    output logic [4:0]                arf_waddr,
    output logic [DATA_WIDTH-1:0]     arf_wdata,
    output logic                      rmap_we,
    output logic [4:0]                rmap_lreg,
    output logic [5:0]                rmap_preg,
    output logic                      st_valid,
    output logic [ADDR_WIDTH-1:0]     st_addr,
    output logic [DATA_WIDTH-1:0]     st_data,
    input  logic                      st_ready,
    output logic [ROB_DEPTH_BITS-1:0] commit_tag,
    output logic [31:0]               commit_count,
    output logic                      sim_pass,
    output logic                      sim_fail,
    output logic                      halted
);

    typedef enum logic [1:0] {RUN, ST_WAIT, HALT} state_t;

    state_t state, state_next;
    logic   head_ok;
    logic   is_store;
    logic   writes_reg;
    logic   is_done;
    logic   capture;

    always_comb begin
        head_ok    = !rob_empty && head_entry.valid && head_entry.ready;
        is_store   = head_entry.inst_type == IT_STORE;
        writes_reg = (head_entry.logic_reg_dest != '0) && !is_store;
        is_done    = head_entry.is_mtc0 && head_entry.mtc0_done;
        state_next = state;
        commit_pop = 1'b0;
        capture    = 1'b0;
        case (state)
            RUN: begin
                if (head_ok && !flush) begin
                    if (is_store) begin
                        capture    = 1'b1;
                        state_next = ST_WAIT;
                    end else begin
                        commit_pop = 1'b1;
                        state_next = is_done ? HALT : RUN;
                    end
                end
            end
            // The head store is already non-speculative, so flush has no say here
            ST_WAIT: begin
                if (st_ready) begin
                    commit_pop = 1'b1;
                    state_next = is_done ? HALT : RUN;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    assign halted = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            arf_we       <= 1'b0;
            arf_waddr    <= '0;
            arf_wdata    <= '0;
            rmap_we      <= 1'b0;
            rmap_lreg    <= '0;
            rmap_preg    <= '0;
            st_valid     <= 1'b0;
            st_addr      <= '0;
            st_data      <= '0;
            commit_tag   <= '0;
            commit_count <= '0;
            sim_pass     <= 1'b0;
            sim_fail     <= 1'b0;
        end else begin
            state   <= state_next;
            arf_we  <= commit_pop && writes_reg;
            rmap_we <= commit_pop && writes_reg;
            if (commit_pop && writes_reg) begin
                arf_waddr <= head_entry.logic_reg_dest;
                arf_wdata <= DATA_WIDTH'(head_entry.value);
                rmap_lreg <= head_entry.logic_reg_dest;
                rmap_preg <= head_entry.reg_dest;
            end
            if (capture) begin
                st_valid <= 1'b1;
                st_addr  <= ADDR_WIDTH'(head_entry.mem_dest);
                st_data  <= DATA_WIDTH'(head_entry.value);
            end else if (state == ST_WAIT && st_ready) begin
                st_valid <= 1'b0;
            end
            if (commit_pop) begin
                commit_tag   <= head_tag;
                commit_count <= commit_count + 32'd1;
                if (head_entry.is_mtc0 && head_entry.mtc0_pass) sim_pass <= 1'b1;
                if (head_entry.is_mtc0 && head_entry.mtc0_fail) sim_fail <= 1'b1;
            end
        end
    end

    logic unused_head;
    assign unused_head = ^{head_entry.pc, head_entry.old_reg_dest, head_entry.branch_taken,
                           head_entry.branch_target, head_entry.mispredict, head_entry.exception,
                           head_entry.inst, head_entry.src_preg_a, head_entry.src_preg_b};

endmodule

// File: tb/tb_rob_commit_unit.sv
// Self-checking bench for rob_commit_unit: directed scenarios plus a randomized
// program checked against an in-order retirement model.
module tb_rob_commit_unit;
    import mips_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rob_empty;
    rob_entry    head_entry;
    logic [4:0]  head_tag;
    logic        flush;
    logic        commit_pop;
    logic        arf_we;
    logic [4:0]  arf_waddr;
    logic [31:0] arf_wdata;
    logic        rmap_we;
    logic [4:0]  rmap_lreg;
    logic [5:0]  rmap_preg;
    logic        st_valid;
    logic [25:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic [4:0]  commit_tag;
    logic [31:0] commit_count;
    logic        sim_pass;
    logic        sim_fail;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    rob_commit_unit #(.ROB_DEPTH_BITS(5), .DATA_WIDTH(32), .ADDR_WIDTH(26)) dut (
        .clk(clk), .rst_n(rst_n), .rob_empty(rob_empty), .head_entry(head_entry),
        .head_tag(head_tag), .flush(flush), .commit_pop(commit_pop),
        .arf_we(arf_we), .arf_waddr(arf_waddr), .arf_wdata(arf_wdata),
        .rmap_we(rmap_we), .rmap_lreg(rmap_lreg), .rmap_preg(rmap_preg),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .commit_tag(commit_tag), .commit_count(commit_count),
        .sim_pass(sim_pass), .sim_fail(sim_fail), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic rob_entry mk(input logic [1:0] t, input logic [4:0] l,
                                    input logic [5:0] p, input logic [31:0] v,
                                    input logic [25:0] m);
        rob_entry e;
        e = '0;
        e.valid = 1'b1;
        e.ready = 1'b1;
        e.inst_type = t;
        e.logic_reg_dest = l;
        e.reg_dest = p;
        e.value = v;
        e.mem_dest = m;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rob_empty = 1'b1;
        head_entry = '0;
        head_tag = '0;
        flush = 1'b0;
        st_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rob_empty = 1'b1;
        head_entry = '0;
        head_tag = '0;
        flush = 1'b0;
        st_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({commit_pop, arf_we, rmap_we, st_valid, sim_pass, sim_fail, halted} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, want 0", {commit_pop, arf_we, rmap_we, st_valid, sim_pass, sim_fail, halted});
        end
        n_tests++;
        if ({arf_waddr, arf_wdata, rmap_lreg, rmap_preg, st_addr, st_data, commit_tag, commit_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: count=%0d tag=%0d addr=%h data=%h wdata=%h, want all 0",
                     commit_count, commit_tag, st_addr, st_data, arf_wdata);
        end
        do_reset();
    endtask

    task automatic test_alu();
        do_reset();
        head_entry = mk(2'b00, 5'd5, 6'd40, 32'hDEADBEEF, 26'h0);
        head_tag = 5'd3;
        rob_empty = 1'b0;
        @(negedge clk);
        n_tests++;
        if (commit_pop !== 1'b1) begin n_fail++; $display("FAIL alu_pop: got %b want 1", commit_pop); end
        n_tests++;
        if (arf_we !== 1'b0) begin n_fail++; $display("FAIL alu_write_early: got %b want 0", arf_we); end
        tick();
        rob_empty = 1'b1;
        @(negedge clk);
        n_tests++;
        if (arf_we !== 1'b1 || rmap_we !== 1'b1 || arf_waddr !== 5'd5 || rmap_lreg !== 5'd5 ||
            arf_wdata !== 32'hDEADBEEF || rmap_preg !== 6'd40) begin
            n_fail++;
            $display("FAIL alu_write: we=%b rwe=%b waddr=%0d lreg=%0d wdata=%h preg=%0d, want 1 1 5 5 deadbeef 40",
                     arf_we, rmap_we, arf_waddr, rmap_lreg, arf_wdata, rmap_preg);
        end
        n_tests++;
        if (commit_count !== 32'd1 || commit_tag !== 5'd3) begin
            n_fail++; $display("FAIL alu_count_tag: count=%0d tag=%0d want 1 3", commit_count, commit_tag);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (arf_we !== 1'b0 || rmap_we !== 1'b0) begin
            n_fail++; $display("FAIL alu_pulse: we=%b rwe=%b want 0 0", arf_we, rmap_we);
        end
    endtask

    task automatic test_store();
        do_reset();
        head_entry = mk(2'b10, 5'd9, 6'd12, 32'h55, 26'h100);
        head_tag = 5'd7;
        rob_empty = 1'b0;
        st_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (commit_pop !== 1'b0 || st_valid !== 1'b0) begin
            n_fail++; $display("FAIL store_first: pop=%b st_valid=%b want 0 0", commit_pop, st_valid);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (st_valid !== 1'b1 || st_addr !== 26'h100 || st_data !== 32'h55 ||
                commit_pop !== 1'b0 || arf_we !== 1'b0) begin
                n_fail++;
                $display("FAIL store_wait%0d: valid=%b addr=%h data=%h pop=%b we=%b want 1 100 55 0 0",
                         i, st_valid, st_addr, st_data, commit_pop, arf_we);
            end
            tick();
        end
        st_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (commit_pop !== 1'b1 || st_valid !== 1'b1) begin
            n_fail++; $display("FAIL store_accept: pop=%b valid=%b want 1 1", commit_pop, st_valid);
        end
        tick();
        st_ready = 1'b0;
        rob_empty = 1'b1;
        @(negedge clk);
        n_tests++;
        if (st_valid !== 1'b0 || arf_we !== 1'b0 || commit_count !== 32'd1 || commit_tag !== 5'd7) begin
            n_fail++;
            $display("FAIL store_done: valid=%b we=%b count=%0d tag=%0d want 0 0 1 7",
                     st_valid, arf_we, commit_count, commit_tag);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] tags [4];
        tags[0] = 5'd30; tags[1] = 5'd31; tags[2] = 5'd0; tags[3] = 5'd1;
        do_reset();
        rob_empty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                head_entry = mk(2'b00, 5'(i + 1), 6'(10 + i), 32'h1000 + 32'(i), 26'h0);
                head_tag = tags[i];
            end else begin
                rob_empty = 1'b1;
            end
            @(negedge clk);
            if (i < 4) begin
                n_tests++;
                if (commit_pop !== 1'b1) begin n_fail++; $display("FAIL b2b_pop%0d: got %b want 1", i, commit_pop); end
            end
            if (i > 0) begin
                n_tests++;
                if (arf_we !== 1'b1 || arf_wdata !== 32'h1000 + 32'(i - 1) || commit_tag !== tags[i-1]) begin
                    n_fail++;
                    $display("FAIL b2b_ret%0d: we=%b wdata=%h tag=%0d want 1 %h %0d",
                             i - 1, arf_we, arf_wdata, commit_tag, 32'h1000 + 32'(i - 1), tags[i-1]);
                end
            end
            tick();
        end
        @(negedge clk);
        n_tests++;
        if (commit_count !== 32'd4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", commit_count); end
    endtask

    task automatic test_mtc0();
        rob_entry e;
        do_reset();
        e = mk(2'b00, 5'd0, 6'd0, 32'h0, 26'h0);
        e.is_mtc0 = 1'b1;
        e.mtc0_pass = 1'b1;
        head_entry = e;
        head_tag = 5'd4;
        rob_empty = 1'b0;
        @(negedge clk);
        n_tests++;
        if (commit_pop !== 1'b1) begin n_fail++; $display("FAIL mtc0_pass_pop: got %b want 1", commit_pop); end
        tick();
        e.mtc0_pass = 1'b0;
        e.mtc0_done = 1'b1;
        head_entry = e;
        head_tag = 5'd5;
        @(negedge clk);
        n_tests++;
        if (sim_pass !== 1'b1 || commit_pop !== 1'b1 || halted !== 1'b0) begin
            n_fail++; $display("FAIL mtc0_done_pop: pass=%b pop=%b halted=%b want 1 1 0", sim_pass, commit_pop, halted);
        end
        tick();
        head_entry = mk(2'b00, 5'd3, 6'd3, 32'h77, 26'h0);
        head_tag = 5'd6;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (halted !== 1'b1 || commit_pop !== 1'b0 || arf_we !== 1'b0 || sim_pass !== 1'b1 || sim_fail !== 1'b0) begin
                n_fail++;
                $display("FAIL mtc0_halt%0d: halted=%b pop=%b we=%b pass=%b fail=%b want 1 0 0 1 0",
                         i, halted, commit_pop, arf_we, sim_pass, sim_fail);
            end
            tick();
        end
        n_tests++;
        if (commit_count !== 32'd2 || commit_tag !== 5'd5) begin
            n_fail++; $display("FAIL mtc0_count: count=%0d tag=%0d want 2 5", commit_count, commit_tag);
        end
    endtask

    task automatic test_flush();
        do_reset();
        head_entry = mk(2'b01, 5'd8, 6'd20, 32'hCAFE0001, 26'h0);
        head_tag = 5'd9;
        rob_empty = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        n_tests++;
        if (commit_pop !== 1'b0) begin n_fail++; $display("FAIL flush_pop: got %b want 0", commit_pop); end
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (arf_we !== 1'b0 || commit_count !== 32'd0 || commit_pop !== 1'b1) begin
            n_fail++; $display("FAIL flush_release: we=%b count=%0d pop=%b want 0 0 1", arf_we, commit_count, commit_pop);
        end
        tick();
        rob_empty = 1'b1;
        @(negedge clk);
        n_tests++;
        if (arf_we !== 1'b1 || arf_wdata !== 32'hCAFE0001 || arf_waddr !== 5'd8) begin
            n_fail++; $display("FAIL flush_write: we=%b wdata=%h waddr=%0d want 1 cafe0001 8", arf_we, arf_wdata, arf_waddr);
        end
    endtask

    task automatic test_reset_in_st_wait();
        do_reset();
        head_entry = mk(2'b10, 5'd0, 6'd0, 32'hA5A5A5A5, 26'h2AB);
        head_tag = 5'd11;
        rob_empty = 1'b0;
        st_ready = 1'b0;
        tick();
        @(negedge clk);
        n_tests++;
        if (st_valid !== 1'b1) begin n_fail++; $display("FAIL rstw_pre: st_valid=%b want 1", st_valid); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({st_valid, commit_pop, arf_we, halted} !== 4'b0 || st_addr !== '0 || st_data !== '0 || commit_count !== '0) begin
            n_fail++;
            $display("FAIL rstw_async: valid=%b pop=%b addr=%h data=%h count=%0d want all 0",
                     st_valid, commit_pop, st_addr, st_data, commit_count);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (st_valid !== 1'b0 || commit_pop !== 1'b0) begin
            n_fail++; $display("FAIL rstw_release: valid=%b pop=%b want 0 0", st_valid, commit_pop);
        end
        tick();
        st_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (st_valid !== 1'b1 || st_addr !== 26'h2AB || st_data !== 32'hA5A5A5A5 || commit_pop !== 1'b1) begin
            n_fail++;
            $display("FAIL rstw_rerequest: valid=%b addr=%h data=%h pop=%b want 1 2ab a5a5a5a5 1",
                     st_valid, st_addr, st_data, commit_pop);
        end
        tick();
        st_ready = 1'b0;
        rob_empty = 1'b1;
    endtask

    task automatic test_random();
        localparam int N = 60;
        rob_entry    prog [$];
        int unsigned dly [$];
        logic [4:0]  ea_l [$];
        logic [31:0] ea_v [$];
        logic [5:0]  ea_p [$];
        logic [25:0] es_a [$];
        logic [31:0] es_d [$];
        rob_entry    cur;
        int unsigned idx, wait_cnt, cycles, start_tag;
        logic        popped, prev_wait;
        logic [4:0]  last_tag;
        logic [25:0] prev_addr;
        logic [31:0] prev_data;

        for (int i = 0; i < N; i++) begin
            logic [1:0]  t;
            logic [4:0]  l;
            logic [5:0]  p;
            logic [31:0] v;
            logic [25:0] m;
            t = 2'($urandom_range(0, 3));
            l = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            p = 6'($urandom_range(0, 63));
            v = $urandom;
            m = 26'($urandom);
            prog.push_back(mk(t, l, p, v, m));
            dly.push_back($urandom_range(0, 3));
            if (t == 2'b10) begin
                es_a.push_back(m); es_d.push_back(v);
            end else if (l != 5'd0) begin
                ea_l.push_back(l); ea_v.push_back(v); ea_p.push_back(p);
            end
        end

        do_reset();
        idx = 0;
        wait_cnt = dly[0];
        cycles = 0;
        start_tag = $urandom_range(0, 31);
        prev_wait = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        last_tag = '0;
        while (idx < N && cycles < 3000) begin
            cur = prog[idx];
            cur.ready = (wait_cnt == 0);
            rob_empty = (wait_cnt != 0) && ($urandom_range(0, 3) == 0);
            head_entry = cur;
            head_tag = 5'(start_tag + idx);
            flush = ($urandom_range(0, 4) == 0);
            st_ready = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (commit_pop) begin
                n_tests++;
                if (rob_empty || !cur.ready) begin
                    n_fail++; $display("FAIL rnd_pop_not_ready: entry %0d popped while not ready", idx);
                end else if (flush && cur.inst_type != 2'b10) begin
                    n_fail++; $display("FAIL rnd_pop_flush: entry %0d popped during flush", idx);
                end else if (cur.inst_type == 2'b10 && !(st_valid && st_ready)) begin
                    n_fail++; $display("FAIL rnd_store_pop: entry %0d valid=%b ready=%b want handshake", idx, st_valid, st_ready);
                end
            end
            if (arf_we) begin
                n_tests++;
                if (ea_l.size() == 0) begin
                    n_fail++; $display("FAIL rnd_arf_extra: waddr=%0d wdata=%h, none expected", arf_waddr, arf_wdata);
                end else begin
                    if (arf_waddr !== ea_l[0] || arf_wdata !== ea_v[0] || rmap_we !== 1'b1 ||
                        rmap_lreg !== ea_l[0] || rmap_preg !== ea_p[0]) begin
                        n_fail++;
                        $display("FAIL rnd_arf: waddr=%0d wdata=%h preg=%0d rwe=%b want %0d %h %0d 1",
                                 arf_waddr, arf_wdata, rmap_preg, rmap_we, ea_l[0], ea_v[0], ea_p[0]);
                    end
                    void'(ea_l.pop_front()); void'(ea_v.pop_front()); void'(ea_p.pop_front());
                end
            end
            if (prev_wait && st_valid) begin
                n_tests++;
                if (st_addr !== prev_addr || st_data !== prev_data) begin
                    n_fail++; $display("FAIL rnd_store_stable: addr=%h data=%h want %h %h", st_addr, st_data, prev_addr, prev_data);
                end
            end
            if (st_valid && st_ready) begin
                n_tests++;
                if (es_a.size() == 0) begin
                    n_fail++; $display("FAIL rnd_store_extra: addr=%h, none expected", st_addr);
                end else begin
                    if (st_addr !== es_a[0] || st_data !== es_d[0]) begin
                        n_fail++; $display("FAIL rnd_store: addr=%h data=%h want %h %h", st_addr, st_data, es_a[0], es_d[0]);
                    end
                    void'(es_a.pop_front()); void'(es_d.pop_front());
                end
            end
            prev_wait = st_valid && !st_ready;
            prev_addr = st_addr;
            prev_data = st_data;
            popped = commit_pop;
            if (popped) last_tag = head_tag;
            tick();
            cycles++;
            if (popped) begin
                idx++;
                if (idx < N) wait_cnt = dly[idx];
            end else if (wait_cnt > 0) begin
                wait_cnt--;
            end
        end
        rob_empty = 1'b1;
        flush = 1'b0;
        st_ready = 1'b0;
        @(negedge clk);
        if (arf_we) begin
            n_tests++;
            if (ea_l.size() == 0 || arf_waddr !== ea_l[0] || arf_wdata !== ea_v[0]) begin
                n_fail++; $display("FAIL rnd_arf_last: waddr=%0d wdata=%h", arf_waddr, arf_wdata);
            end else begin
                void'(ea_l.pop_front()); void'(ea_v.pop_front()); void'(ea_p.pop_front());
            end
        end
        n_tests++;
        if (idx != N) begin n_fail++; $display("FAIL rnd_timeout: retired %0d want %0d", idx, N); end
        n_tests++;
        if (commit_count !== 32'(N) || commit_tag !== last_tag) begin
            n_fail++; $display("FAIL rnd_final: count=%0d tag=%0d want %0d %0d", commit_count, commit_tag, N, last_tag);
        end
        n_tests++;
        if (ea_l.size() != 0 || es_a.size() != 0) begin
            n_fail++; $display("FAIL rnd_missing: arf left=%0d stores left=%0d want 0 0", ea_l.size(), es_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_back_to_back();
        test_mtc0();
        test_flush();
        test_reset_in_st_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
